// File: rtl/countdown16_event_monitor_if.sv
// Event-monitor bus: count/compare inputs, FIFO drain handshake and status outputs.
// master = the environment driving the monitor, slave = the monitor itself.
interface countdown16_event_monitor_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAGW  = 8
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] count_in;
   logic [WIDTH-1:0] cmp_value;
   logic             ev_valid;
   logic             ev_ready;
   logic [1:0]       ev_type;
   logic [TAGW-1:0]  ev_tag;
   logic [TAGW-1:0]  wrap_count;
   logic [LW-1:0]    fifo_level;
   logic             overflow;

   modport master (
      output count_in, cmp_value, ev_ready,
      input  ev_valid, ev_type, ev_tag, wrap_count, fifo_level, overflow
   );

   modport slave (
      input  count_in, cmp_value, ev_ready,
      output ev_valid, ev_type, ev_tag, wrap_count, fifo_level, overflow
   );
endinterface

// File: rtl/countdown16_event_monitor.sv
// Samples a down counter every cycle, detects wrap (0 -> all-ones) and compare-match entry,
// and queues one {type, tag} record per detecting cycle in a first-word-fall-through FIFO.
// Compare detection is built only when COUNTDOWN_MONITOR_CMP_EN is defined; otherwise
// cmp_value is ignored and only wrap records are produced.
module countdown16_event_monitor #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAGW  = 8
) (
   input  logic                        clock0,
   input  logic                        reset,
   countdown16_event_monitor_if.slave  ev_bus
);
   localparam int unsigned PW = $clog2(DEPTH) + 1;
   localparam int unsigned AW = PW - 1;

   typedef struct packed {
      logic [1:0]      typ;
      logic [TAGW-1:0] tag;
   } rec_t;

   logic [WIDTH-1:0] prev_q;
   logic             prev_vld_q;
   logic [TAGW-1:0]  wrap_q, wrap_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             ovf_q, ovf_d;
   rec_t             mem_q [DEPTH];

   logic             wrap_det, cmp_det;
   logic             empty, full, push, pop, push_ok;
   logic [TAGW-1:0]  wrap_inc;
   rec_t             new_rec, head;

`ifndef COUNTDOWN_MONITOR_CMP_EN
   logic unused_cmp;
   assign unused_cmp = ^ev_bus.cmp_value;
`endif

   // Event detection, record formation and FIFO next-state.
   always_comb begin
      wrap_det = prev_vld_q && (prev_q == '0) && (ev_bus.count_in == {WIDTH{1'b1}});
`ifdef COUNTDOWN_MONITOR_CMP_EN
      // Match entry only: a held count produces a single event.
      cmp_det  = prev_vld_q && (ev_bus.count_in == ev_bus.cmp_value) &&
                 (prev_q != ev_bus.count_in);
`else
      cmp_det  = 1'b0;
`endif
      wrap_inc    = wrap_q + TAGW'(1);
      new_rec.typ = {cmp_det, wrap_det};
      new_rec.tag = wrap_det ? wrap_inc : wrap_q;

      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      push    = wrap_det || cmp_det;
      // No bypass: an empty FIFO cannot pop, so a same-cycle push shows up next cycle.
      pop     = !empty && ev_bus.ev_ready;
      push_ok = push && (!full || pop);

      wrap_d   = wrap_det ? wrap_inc : wrap_q;
      wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      ovf_d    = ovf_q || (push && full && !pop);
   end

   // State update; reset discards FIFO contents and history.
   always_ff @(posedge clock0 or negedge reset) begin
      if (!reset) begin
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         wrap_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ovf_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         prev_q     <= ev_bus.count_in;
         prev_vld_q <= 1'b1;
         wrap_q     <= wrap_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ovf_q      <= ovf_d;
         if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= new_rec;
      end
   end

   // Outputs come straight from registered state; head is zeroed while empty.
   always_comb begin
      head              = mem_q[rd_ptr_q[AW-1:0]];
      ev_bus.ev_valid   = !empty;
      ev_bus.ev_type    = empty ? 2'b00 : head.typ;
      ev_bus.ev_tag     = empty ? '0 : head.tag;
      ev_bus.wrap_count = wrap_q;
      ev_bus.fifo_level = wr_ptr_q - rd_ptr_q;
      ev_bus.overflow   = ovf_q;
   end
endmodule

// File: tb/tb_countdown16_event_monitor.sv
// Self-checking bench for countdown16_event_monitor with a queue-based scoreboard.
// Expectations for compare events follow COUNTDOWN_MONITOR_CMP_EN, as in the design.
module tb_countdown16_event_monitor;
`ifdef COUNTDOWN_MONITOR_CMP_EN
   localparam bit CMP_EN = 1'b1;
`else
   localparam bit CMP_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   countdown16_event_monitor_if bus ();

   countdown16_event_monitor dut (
      .clock0 (clk),
      .reset  (rst_n),
      .ev_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state
   logic [9:0]  sb [$];
   logic [15:0] m_prev;
   logic        m_vld;
   logic [7:0]  m_wrap;
   logic        m_ovf;

   task automatic clear_model();
      sb.delete();
      m_prev = 16'h0;
      m_vld  = 1'b0;
      m_wrap = 8'h0;
      m_ovf  = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      clear_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One cycle: predict, check head, clock, check status.
   task automatic step(input logic [15:0] cnt, input logic rdy);
      logic wr, cm;
      logic [9:0] got;
      bus.count_in = cnt;
      bus.ev_ready = rdy;
      #1;
      n_checks++;
      if (bus.ev_valid !== (sb.size() != 0))
         $display("FAIL step_valid: got %b expected %b", bus.ev_valid, sb.size() != 0);
      else n_pass++;
      if (sb.size() != 0) begin
         got = {bus.ev_type, bus.ev_tag};
         n_checks++;
         if (got !== sb[0])
            $display("FAIL step_head: got type %b tag %0h expected type %b tag %0h",
                     got[9:8], got[7:0], sb[0][9:8], sb[0][7:0]);
         else n_pass++;
      end
      wr = m_vld && (m_prev == 16'h0) && (cnt == 16'hFFFF);
      cm = CMP_EN && m_vld && (cnt == bus.cmp_value) && (m_prev != cnt);
      if (rdy && sb.size() != 0) void'(sb.pop_front());
      if (wr) m_wrap++;
      if (wr || cm) begin
         if (sb.size() < 4) sb.push_back({cm, wr, m_wrap});
         else m_ovf = 1'b1;
      end
      m_prev = cnt;
      m_vld  = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.fifo_level !== 3'(sb.size()))
         $display("FAIL step_level: got %0d expected %0d", bus.fifo_level, sb.size());
      else n_pass++;
      n_checks++;
      if (bus.wrap_count !== m_wrap)
         $display("FAIL step_wrap_count: got %0h expected %0h", bus.wrap_count, m_wrap);
      else n_pass++;
      n_checks++;
      if (bus.overflow !== m_ovf)
         $display("FAIL step_overflow: got %b expected %b", bus.overflow, m_ovf);
      else n_pass++;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({bus.ev_valid, bus.ev_type, bus.ev_tag, bus.wrap_count, bus.fifo_level, bus.overflow}
          !== 23'h0)
         $display("FAIL reset_outputs: got v%b t%b tag%0h w%0h l%0d o%b expected all zero",
                  bus.ev_valid, bus.ev_type, bus.ev_tag, bus.wrap_count, bus.fifo_level,
                  bus.overflow);
      else n_pass++;
   endtask

   task automatic test_wrap();
      apply_reset();
      bus.cmp_value = 16'h8000;
      step(16'h0002, 1'b0);
      step(16'h0001, 1'b0);
      step(16'h0000, 1'b0);
      step(16'hFFFF, 1'b0);
      n_checks++;
      if ({bus.ev_valid, bus.ev_type, bus.ev_tag, bus.wrap_count, bus.fifo_level} !==
          {1'b1, 2'b01, 8'h01, 8'h01, 3'd1})
         $display("FAIL wrap_record: got v%b t%b tag%0h w%0h l%0d expected v1 t01 tag1 w1 l1",
                  bus.ev_valid, bus.ev_type, bus.ev_tag, bus.wrap_count, bus.fifo_level);
      else n_pass++;
      step(16'hFFFE, 1'b1);
   endtask

   task automatic test_cmp();
      apply_reset();
      bus.cmp_value = 16'h0005;
      step(16'h0007, 1'b0);
      step(16'h0006, 1'b0);
      step(16'h0005, 1'b0);
      step(16'h0005, 1'b0);
      step(16'h0005, 1'b0);
      n_checks++;
      if (bus.fifo_level !== (CMP_EN ? 3'd1 : 3'd0))
         $display("FAIL cmp_level: got %0d expected %0d", bus.fifo_level, CMP_EN ? 1 : 0);
      else n_pass++;
      if (CMP_EN) begin
         n_checks++;
         if ({bus.ev_type, bus.ev_tag} !== {2'b10, 8'h00})
            $display("FAIL cmp_record: got t%b tag%0h expected t10 tag0", bus.ev_type,
                     bus.ev_tag);
         else n_pass++;
      end
      step(16'h0004, 1'b0);
      step(16'h0003, 1'b1);
   endtask

   task automatic test_both();
      logic [2:0] lvl0;
      bus.cmp_value = 16'hFFFF;
      step(16'h0001, 1'b0);
      step(16'h0000, 1'b0);
      lvl0 = bus.fifo_level;
      step(16'hFFFF, 1'b0);
      n_checks++;
      if (bus.fifo_level !== lvl0 + 3'd1)
         $display("FAIL both_level: got %0d expected %0d", bus.fifo_level, lvl0 + 3'd1);
      else n_pass++;
      n_checks++;
      if ({bus.ev_type, bus.ev_tag} !== {(CMP_EN ? 2'b11 : 2'b01), 8'h01})
         $display("FAIL both_record: got t%b tag%0h expected t%b tag1", bus.ev_type,
                  bus.ev_tag, CMP_EN ? 2'b11 : 2'b01);
      else n_pass++;
      step(16'hFFFE, 1'b1);
   endtask

   task automatic test_overflow();
      apply_reset();
      bus.cmp_value = 16'h8000;
      for (int i = 0; i < 6; i++) begin
         step(16'h0000, 1'b0);
         step(16'hFFFF, 1'b0);
      end
      n_checks++;
      if ({bus.fifo_level, bus.overflow, bus.wrap_count, bus.ev_tag} !==
          {3'd4, 1'b1, 8'd6, 8'd1})
         $display("FAIL ovf_state: got l%0d o%b w%0d tag%0d expected l4 o1 w6 tag1",
                  bus.fifo_level, bus.overflow, bus.wrap_count, bus.ev_tag);
      else n_pass++;
      for (int i = 0; i < 4; i++) step(16'h0100, 1'b1);
      n_checks++;
      if ({bus.ev_valid, bus.overflow} !== 2'b01)
         $display("FAIL ovf_drained: got v%b o%b expected v0 o1", bus.ev_valid, bus.overflow);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      bus.cmp_value = 16'h8000;
      for (int i = 0; i < 4; i++) begin
         step(16'h0000, 1'b0);
         step(16'hFFFF, 1'b0);
      end
      n_checks++;
      if ({bus.fifo_level, bus.overflow} !== {3'd4, 1'b0})
         $display("FAIL full_state: got l%0d o%b expected l4 o0", bus.fifo_level, bus.overflow);
      else n_pass++;
      step(16'h0000, 1'b0);
      step(16'hFFFF, 1'b1);
      n_checks++;
      if ({bus.fifo_level, bus.overflow, bus.wrap_count, bus.ev_tag} !==
          {3'd4, 1'b0, 8'd5, 8'd2})
         $display("FAIL full_push_pop: got l%0d o%b w%0d tag%0d expected l4 o0 w5 tag2",
                  bus.fifo_level, bus.overflow, bus.wrap_count, bus.ev_tag);
      else n_pass++;
      for (int i = 0; i < 4; i++) step(16'h0200, 1'b1);
   endtask

   task automatic test_async_reset();
      apply_reset();
      bus.cmp_value = 16'h8000;
      for (int i = 0; i < 3; i++) begin
         step(16'h0000, 1'b0);
         step(16'hFFFF, 1'b0);
      end
      n_checks++;
      if (bus.fifo_level !== 3'd3)
         $display("FAIL async_pre_level: got %0d expected 3", bus.fifo_level);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.ev_valid, bus.fifo_level, bus.wrap_count, bus.overflow} !== 13'h0)
         $display("FAIL async_reset: got v%b l%0d w%0h o%b expected all zero", bus.ev_valid,
                  bus.fifo_level, bus.wrap_count, bus.overflow);
      else n_pass++;
      clear_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(16'hFFFF, 1'b0);
      n_checks++;
      if ({bus.ev_valid, bus.fifo_level} !== 4'h0)
         $display("FAIL async_first_sample: got v%b l%0d expected v0 l0", bus.ev_valid,
                  bus.fifo_level);
      else n_pass++;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.count_in  = 16'h0;
      bus.cmp_value = 16'h8000;
      bus.ev_ready  = 1'b0;
      clear_model();
      test_reset();
      test_wrap();
      test_cmp();
      test_both();
      test_overflow();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
